// File: rtl/wb_port_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | wb_port_arbiter_pkg : shared backend constants for writeback arbiter |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`ifndef PREG_LENGTH
`define PREG_LENGTH 7
`endif

package wb_port_arbiter_pkg;
    localparam int NUM_REQ     = 4;
    localparam int PREG_LENGTH = `PREG_LENGTH;
    localparam int DATA_W      = 64;

    localparam int REQ_ALU0 = 0;
    localparam int REQ_ALU1 = 1;
    localparam int REQ_MDU  = 2;
    localparam int REQ_LSU  = 3;
endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
// +----------------------------------------------------------------------+
// | wb_port_arbiter_if : requester handshakes and register-file writes   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface wb_port_arbiter_if #(
    parameter int NUM_REQ = wb_port_arbiter_pkg::NUM_REQ
);
    import wb_port_arbiter_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0][PREG_LENGTH-1:0] req_pdst;
    logic [NUM_REQ-1:0][DATA_W-1:0]      req_data;
    logic [NUM_REQ-1:0]                  req_ready;

    logic                   write0_en;
    logic [PREG_LENGTH-1:0] write0_idx;
    logic [DATA_W-1:0]      write0_data;
    logic                   write1_en;
    logic [PREG_LENGTH-1:0] write1_idx;
    logic [DATA_W-1:0]      write1_data;
    logic [PTR_W-1:0]       rr_ptr_dbg;

    modport master (
        output req_valid, req_pdst, req_data,
        input  req_ready,
        input  write0_en, write0_idx, write0_data,
        input  write1_en, write1_idx, write1_data,
        input  rr_ptr_dbg
    );

    modport slave (
        input  req_valid, req_pdst, req_data,
        output req_ready,
        output write0_en, write0_idx, write0_data,
        output write1_en, write1_idx, write1_data,
        output rr_ptr_dbg
    );
endinterface

`default_nettype wire

// File: rtl/defines.sv
`default_nettype none
`ifndef PREG_LENGTH
`define PREG_LENGTH 7
`endif
`ifndef PREG_RANGE
`define PREG_RANGE 6:0
`endif
`default_nettype wire

// File: rtl/rr_pick2.sv
// +----------------------------------------------------------------------+
// | rr_pick2 : picks the first two set bits of a mask in rotating order  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick2 #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  wire  [NUM_REQ-1:0] i_eligible,
    input  wire  [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant0,
    output logic [NUM_REQ-1:0] o_grant1,
    output logic               o_valid0,
    output logic               o_valid1
);
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_grant0 = '0;
        o_grant1 = '0;
        o_valid0 = 1'b0;
        o_valid1 = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_eligible[w_idx]) begin
                if (!o_valid0) begin
                    o_grant0[w_idx] = 1'b1;
                    o_valid0        = 1'b1;
                end else if (!o_valid1) begin
                    o_grant1[w_idx] = 1'b1;
                    o_valid1        = 1'b1;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// +----------------------------------------------------------------------+
// | wb_port_arbiter : round-robin arbiter of writeback requesters onto   |
// | two register-file write ports.                       rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = wb_port_arbiter_pkg::NUM_REQ
) (
    input wire               clock,
    input wire               reset,
    wb_port_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_zero_accept;
    logic [NUM_REQ-1:0] w_shadow;
    logic [NUM_REQ-1:0] w_grant0;
    logic [NUM_REQ-1:0] w_grant1;
    logic               w_valid0;
    logic               w_valid1;
    logic [PTR_W-1:0]   w_idx0;
    logic [PTR_W-1:0]   w_idx1;
    logic [PTR_W-1:0]   w_ptr_next;

    logic [PTR_W-1:0]       r_rr_ptr;
    logic                   r_w0_en;
    logic [PREG_LENGTH-1:0] r_w0_idx;
    logic [DATA_W-1:0]      r_w0_data;
    logic                   r_w1_en;
    logic [PREG_LENGTH-1:0] r_w1_idx;
    logic [DATA_W-1:0]      r_w1_data;

    function automatic logic [PTR_W-1:0] f_scan_pos(input int idx, input logic [PTR_W-1:0] ptr);
        return PTR_W'((idx + NUM_REQ - int'(ptr)) % NUM_REQ);
    endfunction

    function automatic logic [PTR_W-1:0] f_onehot_idx(input logic [NUM_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (oh[i]) idx = PTR_W'(i);
        return idx;
    endfunction

    function automatic logic [PTR_W-1:0] f_wrap_inc(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        w_eligible    = '0;
        w_zero_accept = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i]    = bus.req_valid[i] && (bus.req_pdst[i] != '0);
            w_zero_accept[i] = bus.req_valid[i] && (bus.req_pdst[i] == '0);
        end
    end

    // A requester whose pdst matches an eligible one earlier in scan order is held back,
    // so the two write ports can never target the same register in one cycle.
    always_comb begin
        w_shadow = '0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = 0; j < NUM_REQ; j++)
                if (i != j && w_eligible[j] && (bus.req_pdst[j] == bus.req_pdst[i]) &&
                    (f_scan_pos(j, r_rr_ptr) < f_scan_pos(i, r_rr_ptr)))
                    w_shadow[i] = 1'b1;
    end

    rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_eligible (w_eligible & ~w_shadow),
        .i_ptr      (r_rr_ptr),
        .o_grant0   (w_grant0),
        .o_grant1   (w_grant1),
        .o_valid0   (w_valid0),
        .o_valid1   (w_valid1)
    );

    assign w_idx0 = f_onehot_idx(w_grant0);
    assign w_idx1 = f_onehot_idx(w_grant1);

    always_comb begin
        w_ptr_next = r_rr_ptr;
        if (w_valid1)
            w_ptr_next = f_wrap_inc(w_idx1);
        else if (w_valid0)
            w_ptr_next = f_wrap_inc(w_idx0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_w0_en   <= 1'b0;
            r_w0_idx  <= '0;
            r_w0_data <= '0;
            r_w1_en   <= 1'b0;
            r_w1_idx  <= '0;
            r_w1_data <= '0;
        end else begin
            r_rr_ptr <= w_ptr_next;
            r_w0_en  <= w_valid0;
            r_w1_en  <= w_valid1;
            if (w_valid0) begin
                r_w0_idx  <= bus.req_pdst[w_idx0];
                r_w0_data <= bus.req_data[w_idx0];
            end
            if (w_valid1) begin
                r_w1_idx  <= bus.req_pdst[w_idx1];
                r_w1_data <= bus.req_data[w_idx1];
            end
        end
    end

    assign bus.req_ready   = reset ? '0 : (w_grant0 | w_grant1 | w_zero_accept);
    assign bus.write0_en   = r_w0_en;
    assign bus.write0_idx  = r_w0_idx;
    assign bus.write0_data = r_w0_data;
    assign bus.write1_en   = r_w1_en;
    assign bus.write1_idx  = r_w1_idx;
    assign bus.write1_data = r_w1_data;
    assign bus.rr_ptr_dbg  = r_rr_ptr;
endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_wb_port_arbiter : directed scoreboard bench for wb_port_arbiter   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int PL = PREG_LENGTH;

    typedef logic [3:0][PL-1:0] pd_t;
    typedef logic [3:0][63:0]   dv_t;
    typedef struct packed {
        logic          en0;
        logic [PL-1:0] idx0;
        logic [63:0]   d0;
        logic          en1;
        logic [PL-1:0] idx1;
        logic [63:0]   d1;
    } exp_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    exp_t sb[$];
    logic [3:0] last_rdy;

    wb_port_arbiter_if #(.NUM_REQ(4)) bus ();

    wb_port_arbiter #(.NUM_REQ(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] dat(input int i, input int n);
        return {32'hDA7A_0000 + 32'(n), 32'hC0DE_0000 + 32'(i)};
    endfunction

    function automatic dv_t dv(input int n);
        dv_t r;
        for (int i = 0; i < 4; i++) r[i] = dat(i, n);
        return r;
    endfunction

    function automatic pd_t pd(input int a, input int b, input int c, input int d);
        pd_t r;
        r[0] = PL'(a); r[1] = PL'(b); r[2] = PL'(c); r[3] = PL'(d);
        return r;
    endfunction

    function automatic exp_t mk(input logic e0, input int i0, input logic [63:0] d0,
                                input logic e1, input int i1, input logic [63:0] d1);
        exp_t e;
        e.en0 = e0; e.idx0 = PL'(i0); e.d0 = d0;
        e.en1 = e1; e.idx1 = PL'(i1); e.d1 = d1;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Called at posedge+1: drives a vector, checks ready, queues the expected write, checks rr_ptr.
    task automatic step(input logic [3:0] v, input pd_t p, input dv_t d, input logic [3:0] exp_rdy,
                        input exp_t e, input int exp_ptr, input string nm);
        bus.req_valid = v;
        bus.req_pdst  = p;
        bus.req_data  = d;
        #2;
        last_rdy = bus.req_ready;
        chk({nm, " ready"}, 64'(bus.req_ready), 64'(exp_rdy));
        if (e.en0 || e.en1) sb.push_back(e);
        @(posedge clock);
        #1;
        chk({nm, " rr_ptr"}, 64'(bus.rr_ptr_dbg), 64'(exp_ptr));
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_pdst  = '0;
        bus.req_data  = '0;
    endtask

    // Monitor: every presented write is matched against the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.write0_en || bus.write1_en) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: actual en0=%b idx0=%0d en1=%b idx1=%0d required=no write",
                             bus.write0_en, bus.write0_idx, bus.write1_en, bus.write1_idx);
                end else begin
                    e = sb.pop_front();
                    chk("write0_en", 64'(bus.write0_en), 64'(e.en0));
                    if (e.en0) begin
                        chk("write0_idx", 64'(bus.write0_idx), 64'(e.idx0));
                        chk("write0_data", bus.write0_data, e.d0);
                    end
                    chk("write1_en", 64'(bus.write1_en), 64'(e.en1));
                    if (e.en1) begin
                        chk("write1_idx", 64'(bus.write1_idx), 64'(e.idx1));
                        chk("write1_data", bus.write1_data, e.d1);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t none;
        int   seq[4];
        int   cnt[4];
        int   wt[4];
        int   maxw;
        total = 0;
        bad   = 0;
        none  = '0;
        maxw  = 0;
        for (int i = 0; i < 4; i++) begin seq[i] = 0; cnt[i] = 0; wt[i] = 0; end

        // Reset state with requests present
        reset = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_pdst  = pd(5, 6, 7, 8);
        bus.req_data  = dv(0);
        #3;
        chk("reset ready", 64'(bus.req_ready), 64'(4'b0000));
        repeat (2) @(posedge clock);
        #1;
        chk("reset w0_en", 64'(bus.write0_en), 64'd0);
        chk("reset w1_en", 64'(bus.write1_en), 64'd0);
        chk("reset rr_ptr", 64'(bus.rr_ptr_dbg), 64'd0);
        chk("reset w0_idx", 64'(bus.write0_idx), 64'd0);
        chk("reset w1_data", bus.write1_data, 64'd0);
        idle();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Four requesters, two grants per cycle
        step(4'b1111, pd(5, 6, 7, 8), dv(1), 4'b0011,
             mk(1, 5, dat(REQ_ALU0, 1), 1, 6, dat(REQ_ALU1, 1)), 2, "all4_a");
        step(4'b1100, pd(5, 6, 7, 8), dv(1), 4'b1100,
             mk(1, 7, dat(REQ_MDU, 1), 1, 8, dat(REQ_LSU, 1)), 0, "all4_b");
        // Single requester at the far end of the scan
        step(4'b1000, pd(0, 0, 0, 9), dv(2), 4'b1000,
             mk(1, 9, dat(REQ_LSU, 2), 0, 0, 64'd0), 0, "lsu_only");
        // Same pdst: later one held
        step(4'b0110, pd(0, 12, 12, 0), dv(3), 4'b0010,
             mk(1, 12, dat(REQ_ALU1, 3), 0, 0, 64'd0), 2, "same_pdst_a");
        step(4'b0100, pd(0, 12, 12, 0), dv(3), 4'b0100,
             mk(1, 12, dat(REQ_MDU, 3), 0, 0, 64'd0), 3, "same_pdst_b");
        // pdst 0 accepted without a write port
        step(4'b0011, pd(0, 3, 0, 0), dv(4), 4'b0011,
             mk(1, 3, dat(REQ_ALU1, 4), 0, 0, 64'd0), 2, "pdst_zero");
        // Wrapped scan with a three-way pdst collision
        step(4'b1111, pd(4, 10, 4, 4), dv(5), 4'b0110,
             mk(1, 4, dat(REQ_MDU, 5), 1, 10, dat(REQ_ALU1, 5)), 2, "collide_a");
        step(4'b1001, pd(4, 10, 4, 4), dv(5), 4'b1000,
             mk(1, 4, dat(REQ_LSU, 5), 0, 0, 64'd0), 0, "collide_b");
        step(4'b0001, pd(4, 10, 4, 4), dv(5), 4'b0001,
             mk(1, 4, dat(REQ_ALU0, 5), 0, 0, 64'd0), 1, "collide_c");

        // Fairness: all continuously valid, grants alternate {1,2} and {3,0}
        for (int c = 0; c < 8; c++) begin
            dv_t d;
            for (int i = 0; i < 4; i++) d[i] = dat(i, 100 + seq[i]);
            if (c % 2 == 0)
                step(4'b1111, pd(20, 21, 22, 23), d, 4'b0110,
                     mk(1, 21, d[1], 1, 22, d[2]), 3, "fair");
            else
                step(4'b1111, pd(20, 21, 22, 23), d, 4'b1001,
                     mk(1, 23, d[3], 1, 20, d[0]), 1, "fair");
            for (int i = 0; i < 4; i++) begin
                if (last_rdy[i]) begin
                    cnt[i]++;
                    seq[i]++;
                    wt[i] = 0;
                end else begin
                    wt[i]++;
                    if (wt[i] > maxw) maxw = wt[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) chk("fair grant count", 64'(cnt[i]), 64'd4);
        chk("fair max wait <= 3", 64'(maxw <= 3), 64'd1);

        // Reset right after a grant lands on the write port
        step(4'b0001, pd(15, 0, 0, 0), dv(6), 4'b0001, none, 1, "pre_reset");
        chk("pre_reset w0_en", 64'(bus.write0_en), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_reset w0_en", 64'(bus.write0_en), 64'd0);
        chk("mid_reset w1_en", 64'(bus.write1_en), 64'd0);
        chk("mid_reset w0_idx", 64'(bus.write0_idx), 64'd0);
        chk("mid_reset w0_data", bus.write0_data, 64'd0);
        chk("mid_reset ready", 64'(bus.req_ready), 64'd0);
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_reset w0_en", 64'(bus.write0_en), 64'd0);
        @(posedge clock);
        #1;
        chk("post_reset rr_ptr", 64'(bus.rr_ptr_dbg), 64'd0);
        chk("post_reset w0_en", 64'(bus.write0_en), 64'd0);

        step(4'b1111, pd(5, 6, 7, 8), dv(7), 4'b0011,
             mk(1, 5, dat(REQ_ALU0, 7), 1, 6, dat(REQ_ALU1, 7)), 2, "after_reset");
        idle();
        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of writeback requesters (ALU0, ALU1, MDU, LSU).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, NUM_REQ, per-requester writeback valid.
REQ-005 SHALL have port req_pdst, input, NUM_REQ x PREG_LENGTH, per-requester destination physical register.
REQ-006 SHALL have port req_data, input, NUM_REQ x 64, per-requester result.
REQ-007 SHALL have port req_ready, output, NUM_REQ, accept strobe; a transfer occurs when valid and ready are both high.
REQ-008 SHALL have ports write0_en/write0_idx/write0_data and write1_en/write1_idx/write1_data, outputs, 1/PREG_LENGTH/64 each, driving the two register-file write ports.
REQ-009 SHALL have port rr_ptr_dbg, output, log2(NUM_REQ), current round-robin pointer.

Function
REQ-010 SHALL grant at most two requests per cycle; the first grant goes to port 0 and the second to port 1.
REQ-011 SHALL scan requesters in rotating order rr_ptr, rr_ptr+1, ... mod NUM_REQ and grant the first two eligible ones.
REQ-012 SHALL treat a requester as eligible when req_valid=1 and req_pdst!=0.
REQ-013 SHALL assert req_ready=1 for a valid request with req_pdst==0 in the same cycle, without using a write port and without asserting any write enable.
REQ-014 SHALL, when two eligible requests in one cycle carry the same pdst, grant only the one earlier in scan order and hold the other (ready=0) until a later cycle.
REQ-015 SHALL make req_ready combinational from the current inputs and rr_ptr, with no dependence on any later cycle.
REQ-016 SHALL register write outputs: a grant in cycle N drives writeN_en/idx/data in cycle N+1 (latency 1); when no grant exists, the en output is 0 and idx/data hold their previous values.
REQ-017 SHALL update rr_ptr to (index of last granted requester + 1) mod NUM_REQ; with zero grants rr_ptr SHALL be unchanged; pdst==0 acceptances SHALL NOT move rr_ptr.
REQ-018 SHALL never drive write0_en and write1_en in the same cycle with equal idx.
REQ-019 SHALL guarantee a continuously valid eligible requester is granted within NUM_REQ-1 cycles (no starvation).
REQ-020 SHALL hold a request until accepted; the arbiter SHALL NOT drop or duplicate a transfer.

Reset
REQ-021 SHALL, on reset assertion at any time (including mid-grant), force rr_ptr=0, write0_en=0, write1_en=0, write*_idx=0, and write*_data=0 asynchronously.
REQ-022 SHALL, while reset is high, drive req_ready=0 for all requesters.
REQ-023 SHALL discard any grant registered before a mid-operation reset; no write SHALL appear on the cycle after reset deasserts.

Structure
REQ-024 SHALL take PREG_LENGTH/PREG_RANGE from defines.sv and place NUM_REQ and the requester index constants (REQ_ALU0=0, REQ_ALU1=1, REQ_MDU=2, REQ_LSU=3) in the shared backend package.
REQ-025 SHALL implement rotating first-two selection in one combinational sub-module, rr_pick2 (inputs: eligible mask, pointer; outputs: two one-hot grants plus valid bits).
REQ-026 SHALL keep all state (rr_ptr, output registers) in wb_port_arbiter.

Verification
REQ-027 Reset, then all four valid with pdst 5,6,7,8 -> cycle 0 grants req0/req1, cycle 1 shows write0=(5,d0), write1=(6,d1), rr_ptr=2; the next cycle grants req2/req3.
REQ-028 Only req3 valid with pdst=9, rr_ptr=0 -> req_ready=0b1000, next cycle write0_en=1, idx=9, write1_en=0, rr_ptr=0.
REQ-029 req1 and req2 both valid with pdst=12, rr_ptr=0 -> ready=0b0010 only, write0_idx=12; req2 is granted the following cycle.
REQ-030 req0 valid with pdst=0 plus req1 with pdst=3 -> ready=0b0011, only write0 (idx=3) asserted, rr_ptr=2.
REQ-031 All four continuously valid for 8 cycles -> each requester is granted exactly 4 times, and the maximum wait is at most 3 cycles.
REQ-032 Assert reset in the cycle after a grant -> write0_en and write1_en go to 0 immediately, and rr_ptr=0 after reset is released.
